// File: rtl/pcseq_pkg.sv
// pcseq_pkg: shared types and constants for the PC sequencer.
package pcseq_pkg;
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pcseq_state_e;
    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;
    localparam int PCSEQ_ADDR_W = 20;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control, branch and PC signals between fetch/decode and the sequencer.
interface pc_sequencer_if import pcseq_pkg::*; #(parameter int ADDR_W = PCSEQ_ADDR_W);
    logic              stall;
    logic              halt;
    logic              resume;
    logic              flag_we;
    logic [2:0]        flag_in;
    logic              br_valid;
    logic [2:0]        br_nzp;
    logic [ADDR_W-1:0] br_offset;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              taken;
    logic [2:0]        flags;
    logic              ras_err;
    modport master (
        output stall, halt, resume, flag_we, flag_in, br_valid, br_nzp, br_offset, call, ret, target,
        input  pc, pc_valid, taken, flags, ras_err
    );
    modport slave (
        input  stall, halt, resume, flag_we, flag_in, br_valid, br_nzp, br_offset, call, ret, target,
        output pc, pc_valid, taken, flags, ras_err
    );
endinterface

// File: rtl/pcseq_ras.sv
// pcseq_ras: circular return-address stack; a full push overwrites the oldest entry.
module pcseq_ras #(
    parameter int ADDR_W = 20,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] pushData,
    output logic [ADDR_W-1:0] topData,
    output logic              empty,
    output logic              err
);
    localparam int PW = $clog2(DEPTH);
    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PW-1:0]     top, topInc;
    logic [PW:0]       count;
    logic              full;
    assign topInc  = top + PW'(1);
    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign topData = mem[top];
    always_ff @(posedge clk)
        if (push) mem[topInc] <= pushData;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            top   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (push) begin
            top   <= topInc;
            count <= full ? count : count + (PW+1)'(1);
            err   <= full;
        end else if (pop) begin
            top   <= empty ? top : top - PW'(1);
            count <= empty ? count : count - (PW+1)'(1);
            err   <= empty;
        end else begin
            err   <= 1'b0;
        end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered PC and NZP sequencer with branch, call/ret, stall and halt.
// Defining PCSEQ_RAS_EN adds a return-address stack; otherwise ret falls through to PC+1.
module pc_sequencer import pcseq_pkg::*; #(
    parameter int                ADDR_W    = PCSEQ_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);
    localparam logic [1:0] BOOT = ST_BOOT;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] HALT = ST_HALT;
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : gBadDepth
        $error("RAS_DEPTH must be a power of two >= 2");
    end
    logic [1:0]        state;
    logic [ADDR_W-1:0] pcReg, pcInc, pcNext, retAddr;
    logic [2:0]        flagReg, effFlags;
    logic              takenReg, active, brTaken, popOk, redirect, rasErr;
    assign active   = state == RUN && !bus.stall && !bus.halt;
    assign effFlags = bus.flag_we ? bus.flag_in : flagReg;
    assign brTaken  = bus.br_valid && |(bus.br_nzp & effFlags);
    assign pcInc    = pcReg + ADDR_W'(1);
`ifdef PCSEQ_RAS_EN
    logic rasEmpty;
    pcseq_ras #(.ADDR_W(ADDR_W), .DEPTH(RAS_DEPTH)) uRas (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (active && !bus.ret && bus.call),
        .pop      (active && bus.ret),
        .pushData (pcInc),
        .topData  (retAddr),
        .empty    (rasEmpty),
        .err      (rasErr)
    );
    assign popOk = bus.ret && !rasEmpty;
`else
    assign retAddr = pcInc;
    assign popOk   = 1'b0;
    assign rasErr  = 1'b0;
`endif
    // A ret that cannot pop still outranks call/branch and just falls through.
    always_comb begin
        pcNext   = popOk ? retAddr :
                   bus.ret ? pcInc :
                   bus.call ? bus.target :
                   brTaken ? pcReg + bus.br_offset : pcInc;
        redirect = popOk || (!bus.ret && (bus.call || brTaken));
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= BOOT;
            pcReg    <= RESET_PC;
            takenReg <= 1'b0;
            flagReg  <= CC_Z;
        end else begin
            flagReg <= effFlags;
            if (state == BOOT)
                state <= RUN;
            else if (state == RUN && bus.halt && !bus.stall)
                state <= HALT;
            else if (state == HALT && !bus.stall && bus.resume && !bus.halt)
                state <= RUN;
            if (!bus.stall) takenReg <= active && redirect;
            if (active) pcReg <= pcNext;
        end
    assign bus.pc       = pcReg;
    assign bus.pc_valid = state == RUN;
    assign bus.taken    = takenReg;
    assign bus.flags    = flagReg;
    assign bus.ras_err  = rasErr;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus checked against a behavioural PC model.
module tb_pc_sequencer;
    localparam int AW    = 20;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    pc_sequencer_if #(.ADDR_W(AW)) bus();
    pc_sequencer #(.ADDR_W(AW), .RESET_PC(20'h0), .RAS_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;

    // Model: mode 0 = boot, 1 = running, 2 = halted
    logic [AW-1:0] mPc;
    int            mMode;
    logic          mTaken, mErr;
    logic [2:0]    mFlags;
    logic [AW-1:0] ras[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void modelReset();
        mPc = '0; mMode = 0; mTaken = 1'b0; mErr = 1'b0; mFlags = 3'b010;
        ras.delete();
    endfunction

    function automatic void modelStep();
        logic [2:0]    ef;
        logic [AW-1:0] seq;
        ef     = bus.flag_we ? bus.flag_in : mFlags;
        mFlags = ef;
        mErr   = 1'b0;
        seq    = mPc + 20'd1;
        if (mMode == 0) mMode = 1;
        else if (bus.stall) ;
        else if (mMode == 2) begin
            mTaken = 1'b0;
            if (bus.resume && !bus.halt) mMode = 1;
        end else if (bus.halt) begin
            mMode = 2; mTaken = 1'b0;
        end else if (bus.ret) begin
`ifdef PCSEQ_RAS_EN
            if (ras.size() > 0) begin mPc = ras.pop_back(); mTaken = 1'b1; end
            else begin mPc = seq; mTaken = 1'b0; mErr = 1'b1; end
`else
            mPc = seq; mTaken = 1'b0;
`endif
        end else if (bus.call) begin
`ifdef PCSEQ_RAS_EN
            ras.push_back(seq);
            if (ras.size() > DEPTH) begin void'(ras.pop_front()); mErr = 1'b1; end
`endif
            mPc = bus.target; mTaken = 1'b1;
        end else if (bus.br_valid && (bus.br_nzp & ef) != 3'b000) begin
            mPc = mPc + bus.br_offset; mTaken = 1'b1;
        end else begin
            mPc = seq; mTaken = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        check("pc", 32'(bus.pc), 32'(mPc));
        check("pc_valid", 32'(bus.pc_valid), 32'(mMode == 1));
        check("taken", 32'(bus.taken), 32'(mTaken));
        check("flags", 32'(bus.flags), 32'(mFlags));
        check("ras_err", 32'(bus.ras_err), 32'(mErr));
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            if (rst_n) modelStep();
            #1;
        end
    endtask

    task automatic idle();
        bus.stall = 0; bus.halt = 0; bus.resume = 0; bus.flag_we = 0; bus.flag_in = 0;
        bus.br_valid = 0; bus.br_nzp = 0; bus.br_offset = 0; bus.call = 0; bus.ret = 0; bus.target = 0;
    endtask

    initial begin
        idle();
        modelReset();
        tick(2);
        check("rst_pc", 32'(bus.pc), 32'h0);
        check("rst_valid", 32'(bus.pc_valid), 32'h0);
        check("rst_taken", 32'(bus.taken), 32'h0);
        check("rst_flags", 32'(bus.flags), 32'h2);
        check("rst_ras_err", 32'(bus.ras_err), 32'h0);
        rst_n = 1;
        tick();
        check("boot_pc", 32'(bus.pc), 32'h0);
        check("boot_valid", 32'(bus.pc_valid), 32'h1);
        tick(5);
        check("count_pc", 32'(bus.pc), 32'h5);
        bus.br_valid = 1; bus.br_nzp = 3'b100; bus.br_offset = 20'h00010;
        tick();
        check("br_nt_pc", 32'(bus.pc), 32'h6);
        check("br_nt_taken", 32'(bus.taken), 32'h0);
        bus.br_nzp = 3'b010;
        tick();
        check("br_t_pc", 32'(bus.pc), 32'h16);
        check("br_t_taken", 32'(bus.taken), 32'h1);
        idle();
        rst_n = 0; modelReset();
        #1;
        check("async_rst_pc", 32'(bus.pc), 32'h0);
        check("async_rst_valid", 32'(bus.pc_valid), 32'h0);
        tick();
        rst_n = 1;
        tick(4);
        check("pc3", 32'(bus.pc), 32'h3);
        bus.flag_we = 1; bus.flag_in = 3'b001; bus.br_valid = 1; bus.br_nzp = 3'b001; bus.br_offset = 20'hFFFFE;
        tick();
        check("bypass_pc", 32'(bus.pc), 32'h1);
        check("bypass_flags", 32'(bus.flags), 32'h1);
        bus.flag_we = 0;
        tick();
        check("neg_off_pc", 32'(bus.pc), 32'hFFFFF);
        idle();
        bus.stall = 1;
        tick(3);
        check("stall_pc", 32'(bus.pc), 32'hFFFFF);
        check("stall_taken", 32'(bus.taken), 32'h1);
        bus.stall = 0;
        tick();
        check("wrap_pc", 32'(bus.pc), 32'h0);
        check("wrap_taken", 32'(bus.taken), 32'h0);
        bus.halt = 1;
        tick(3);
        check("halt_valid", 32'(bus.pc_valid), 32'h0);
        check("halt_pc", 32'(bus.pc), 32'h0);
        bus.halt = 0; bus.resume = 1;
        tick();
        bus.resume = 0;
        check("resume_valid", 32'(bus.pc_valid), 32'h1);
        tick(7);
        check("pc7", 32'(bus.pc), 32'h7);
        bus.call = 1; bus.target = 20'h00100;
        tick();
        check("call_pc", 32'(bus.pc), 32'h100);
        bus.call = 0; bus.ret = 1;
        tick();
`ifdef PCSEQ_RAS_EN
        check("ret_pc", 32'(bus.pc), 32'h8);
        check("ret_taken", 32'(bus.taken), 32'h1);
        bus.ret = 0; bus.call = 1;
        for (int i = 0; i < 5; i++) begin
            bus.target = 20'h00200 + 20'(i);
            tick();
            check("nest_ras_err", 32'(bus.ras_err), 32'(i == 4));
        end
        bus.call = 0; bus.ret = 1;
        tick(4);
        check("unwind_pc", 32'(bus.pc), 32'h201);
        tick();
        check("empty_ret_pc", 32'(bus.pc), 32'h202);
        check("empty_ret_err", 32'(bus.ras_err), 32'h1);
`else
        check("ret_pc", 32'(bus.pc), 32'h101);
        check("ret_ras_err", 32'(bus.ras_err), 32'h0);
`endif
        idle();
        for (int i = 0; i < 3000; i++) begin
            bus.stall     = $urandom_range(0, 99) < 15;
            bus.halt      = $urandom_range(0, 99) < 4;
            bus.resume    = $urandom_range(0, 99) < 30;
            bus.flag_we   = $urandom_range(0, 99) < 30;
            bus.flag_in   = 3'($urandom);
            bus.br_valid  = $urandom_range(0, 99) < 30;
            bus.br_nzp    = 3'($urandom);
            bus.br_offset = $urandom_range(0, 3) == 0 ? 20'($urandom) : 20'($signed(8'($urandom)));
            bus.call      = $urandom_range(0, 99) < 12;
            bus.ret       = $urandom_range(0, 99) < 12;
            bus.target    = 20'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 0; modelReset();
                tick();
                rst_n = 1;
            end
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
